// File: rtl/multi_blob_tracker.sv
// Multi-channel mask tracker: per-frame centroid, bounding box and found flag
// for CHANNELS masks, using one shared bit-serial restoring divider.
module multi_blob_tracker #(
    parameter int CHANNELS  = 4,
    parameter int H_WIDTH   = 11,
    parameter int V_WIDTH   = 10,
    parameter int WIDTH     = 1024,
    parameter int HEIGHT    = 768,
    parameter int MIN_COUNT = 16
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic [H_WIDTH-1:0]           x_in,
    input  logic [V_WIDTH-1:0]           y_in,
    input  logic [CHANNELS-1:0]          mask_in,
    input  logic                         tabulate_in,
    output logic                         busy_out,
    output logic                         valid_out,
    output logic                         overrun_out,
    output logic [CHANNELS-1:0]          found_out,
    output logic [CHANNELS*H_WIDTH-1:0]  x_com_out,
    output logic [CHANNELS*V_WIDTH-1:0]  y_com_out,
    output logic [CHANNELS*H_WIDTH-1:0]  left_out,
    output logic [CHANNELS*H_WIDTH-1:0]  right_out,
    output logic [CHANNELS*V_WIDTH-1:0]  top_out,
    output logic [CHANNELS*V_WIDTH-1:0]  bot_out
);

    localparam int CW  = $clog2(WIDTH*HEIGHT+1);
    localparam int SXW = H_WIDTH + CW;
    localparam int SYW = V_WIDTH + CW;
    localparam int NB  = (H_WIDTH > V_WIDTH) ? H_WIDTH : V_WIDTH;
    localparam int CHW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int CYW = $clog2(H_WIDTH+V_WIDTH+1);

    localparam logic [H_WIDTH:0] X_LIM   = (H_WIDTH+1)'(WIDTH);
    localparam logic [V_WIDTH:0] Y_LIM   = (V_WIDTH+1)'(HEIGHT);
    localparam logic [CYW-1:0]   X_LAST  = CYW'(H_WIDTH);
    localparam logic [CYW-1:0]   Y_LAST  = CYW'(H_WIDTH+V_WIDTH);
    localparam logic [CW-1:0]    MIN_CNT = CW'(MIN_COUNT);
    localparam logic [CHW-1:0]   CH_LAST = CHW'(CHANNELS-1);

    typedef enum logic [1:0] {IDLE, DIVIDE, DONE} state_t;
    state_t state, state_nx;

    logic [CW-1:0]      acc_cnt  [CHANNELS];
    logic [SXW-1:0]     acc_sx   [CHANNELS];
    logic [SYW-1:0]     acc_sy   [CHANNELS];
    logic [H_WIDTH-1:0] acc_minx [CHANNELS];
    logic [H_WIDTH-1:0] acc_maxx [CHANNELS];
    logic [V_WIDTH-1:0] acc_miny [CHANNELS];
    logic [V_WIDTH-1:0] acc_maxy [CHANNELS];

    logic [CW-1:0]      sh_cnt  [CHANNELS];
    logic [SXW-1:0]     sh_sx   [CHANNELS];
    logic [SYW-1:0]     sh_sy   [CHANNELS];
    logic [H_WIDTH-1:0] sh_minx [CHANNELS];
    logic [H_WIDTH-1:0] sh_maxx [CHANNELS];
    logic [V_WIDTH-1:0] sh_miny [CHANNELS];
    logic [V_WIDTH-1:0] sh_maxy [CHANNELS];

    logic [H_WIDTH-1:0]  st_x [CHANNELS];
    logic [V_WIDTH-1:0]  st_y [CHANNELS];
    logic [CHANNELS-1:0] st_found;

    logic [CHW-1:0] ch;
    logic [CYW-1:0] cyc;
    logic [CW-1:0]  rem, dvs, rem_nx, diff;
    logic [NB-1:0]  num_lo, quo, quo_nx;
    logic [CW:0]    trial;
    logic           ge, ch_found, in_range, accept;
    logic [CHANNELS-1:0] hit;

    assign in_range  = ({1'b0, x_in} < X_LIM) && ({1'b0, y_in} < Y_LIM);
    assign hit       = mask_in & {CHANNELS{in_range}};
    assign accept    = tabulate_in && (state == IDLE);
    assign busy_out  = (state != IDLE);
    assign valid_out = (state == DONE);
    assign ch_found  = (sh_cnt[ch] >= MIN_CNT);

    always_comb begin
        trial  = {rem, num_lo[NB-1]};
        ge     = (trial >= {1'b0, dvs});
        diff   = trial[CW-1:0] - dvs;
        rem_nx = ge ? diff : trial[CW-1:0];
        quo_nx = {quo[NB-2:0], ge};
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state       <= IDLE;
            overrun_out <= 1'b0;
        end else begin
            state       <= state_nx;
            overrun_out <= tabulate_in && (state != IDLE);
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (tabulate_in) state_nx = DIVIDE;
            DIVIDE:  if (cyc == Y_LAST && ch == CH_LAST) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // A strobe clears every channel, then the same cycle's pixel seeds the new frame.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                acc_cnt[c]  <= '0;
                acc_sx[c]   <= '0;
                acc_sy[c]   <= '0;
                acc_minx[c] <= '1;
                acc_maxx[c] <= '0;
                acc_miny[c] <= '1;
                acc_maxy[c] <= '0;
            end
        end else begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                if (tabulate_in) begin
                    acc_cnt[c]  <= hit[c] ? CW'(1) : '0;
                    acc_sx[c]   <= hit[c] ? SXW'(x_in) : '0;
                    acc_sy[c]   <= hit[c] ? SYW'(y_in) : '0;
                    acc_minx[c] <= hit[c] ? x_in : '1;
                    acc_maxx[c] <= hit[c] ? x_in : '0;
                    acc_miny[c] <= hit[c] ? y_in : '1;
                    acc_maxy[c] <= hit[c] ? y_in : '0;
                end else if (hit[c]) begin
                    acc_cnt[c]  <= acc_cnt[c] + CW'(1);
                    acc_sx[c]   <= acc_sx[c] + SXW'(x_in);
                    acc_sy[c]   <= acc_sy[c] + SYW'(y_in);
                    if (x_in < acc_minx[c]) acc_minx[c] <= x_in;
                    if (x_in > acc_maxx[c]) acc_maxx[c] <= x_in;
                    if (y_in < acc_miny[c]) acc_miny[c] <= y_in;
                    if (y_in > acc_maxy[c]) acc_maxy[c] <= y_in;
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                sh_cnt[c]  <= '0;
                sh_sx[c]   <= '0;
                sh_sy[c]   <= '0;
                sh_minx[c] <= '0;
                sh_maxx[c] <= '0;
                sh_miny[c] <= '0;
                sh_maxy[c] <= '0;
            end
        end else if (accept) begin
            sh_cnt  <= acc_cnt;
            sh_sx   <= acc_sx;
            sh_sy   <= acc_sy;
            sh_minx <= acc_minx;
            sh_maxx <= acc_maxx;
            sh_miny <= acc_miny;
            sh_maxy <= acc_maxy;
        end
    end

    // The last x step also loads the y dividend, so y needs no separate load cycle.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            ch        <= '0;
            cyc       <= '0;
            rem       <= '0;
            dvs       <= '0;
            num_lo    <= '0;
            quo       <= '0;
            st_found  <= '0;
            found_out <= '0;
            x_com_out <= '0;
            y_com_out <= '0;
            left_out  <= '0;
            right_out <= '0;
            top_out   <= '0;
            bot_out   <= '0;
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                st_x[c] <= '0;
                st_y[c] <= '0;
            end
        end else if (state == DIVIDE) begin
            if (cyc == Y_LAST) begin
                cyc <= '0;
                ch  <= ch + CHW'(1);
            end else begin
                cyc <= cyc + CYW'(1);
            end
            if (cyc == '0) begin
                st_found[ch] <= ch_found;
                dvs    <= ch_found ? sh_cnt[ch] : CW'(1);
                rem    <= sh_sx[ch][H_WIDTH +: CW];
                num_lo <= NB'(sh_sx[ch][H_WIDTH-1:0]) << (NB-H_WIDTH);
                quo    <= '0;
            end else begin
                rem    <= rem_nx;
                num_lo <= num_lo << 1;
                quo    <= quo_nx;
                if (cyc == X_LAST) begin
                    st_x[ch] <= quo_nx[H_WIDTH-1:0];
                    rem      <= sh_sy[ch][V_WIDTH +: CW];
                    num_lo   <= NB'(sh_sy[ch][V_WIDTH-1:0]) << (NB-V_WIDTH);
                end
                if (cyc == Y_LAST) begin
                    st_y[ch] <= quo_nx[V_WIDTH-1:0];
                    if (ch == CH_LAST) begin
                        found_out <= st_found;
                        for (int unsigned c = 0; c < CHANNELS; c++) begin
                            if (st_found[c]) begin
                                x_com_out[c*H_WIDTH +: H_WIDTH] <= st_x[c];
                                y_com_out[c*V_WIDTH +: V_WIDTH] <=
                                    (CHW'(c) == ch) ? quo_nx[V_WIDTH-1:0] : st_y[c];
                                left_out[c*H_WIDTH +: H_WIDTH]  <= sh_minx[c];
                                right_out[c*H_WIDTH +: H_WIDTH] <= sh_maxx[c];
                                top_out[c*V_WIDTH +: V_WIDTH]   <= sh_miny[c];
                                bot_out[c*V_WIDTH +: V_WIDTH]   <= sh_maxy[c];
                            end
                        end
                    end
                end
            end
        end else begin
            ch  <= '0;
            cyc <= '0;
        end
    end

endmodule

// File: tb/tb_multi_blob_tracker.sv
// Directed bench for multi_blob_tracker with a behavioural model feeding an
// expected-result queue that is drained whenever valid_out pulses.
module tb_multi_blob_tracker;

    localparam int CH = 4, HW = 11, VW = 10, LAT = 89, MINC = 16;

    typedef struct {
        int unsigned        cyc;
        logic [CH-1:0]      found;
        logic [CH*HW-1:0]   x, l, r;
        logic [CH*VW-1:0]   y, t, b;
    } exp_t;

    logic clk = 1'b0, rst_n = 1'b1;
    logic [HW-1:0] x_in = '0;
    logic [VW-1:0] y_in = '0;
    logic [CH-1:0] mask_in = '0;
    logic tabulate_in = 1'b0;
    logic busy_out, valid_out, overrun_out;
    logic [CH-1:0] found_out;
    logic [CH*HW-1:0] x_com_out, left_out, right_out;
    logic [CH*VW-1:0] y_com_out, top_out, bot_out;

    int unsigned cyc_n = 0;
    int n_tests = 0, n_fail = 0, ovr_cnt = 0;
    exp_t sb[$];

    int m_cnt[CH], m_sx[CH], m_sy[CH], m_minx[CH], m_maxx[CH], m_miny[CH], m_maxy[CH];
    logic [HW-1:0] h_x[CH], h_l[CH], h_r[CH];
    logic [VW-1:0] h_y[CH], h_t[CH], h_b[CH];

    multi_blob_tracker #(.CHANNELS(CH), .H_WIDTH(HW), .V_WIDTH(VW), .WIDTH(1024),
                         .HEIGHT(768), .MIN_COUNT(MINC)) dut (
        .clk_in(clk), .rst_in(rst_n), .x_in(x_in), .y_in(y_in), .mask_in(mask_in),
        .tabulate_in(tabulate_in), .busy_out(busy_out), .valid_out(valid_out),
        .overrun_out(overrun_out), .found_out(found_out), .x_com_out(x_com_out),
        .y_com_out(y_com_out), .left_out(left_out), .right_out(right_out),
        .top_out(top_out), .bot_out(bot_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic m_clear();
        for (int c = 0; c < CH; c++) begin
            m_cnt[c] = 0; m_sx[c] = 0; m_sy[c] = 0;
            m_minx[c] = 1 << 30; m_maxx[c] = -1;
            m_miny[c] = 1 << 30; m_maxy[c] = -1;
        end
    endtask

    task automatic h_clear();
        for (int c = 0; c < CH; c++) begin
            h_x[c] = '0; h_l[c] = '0; h_r[c] = '0;
            h_y[c] = '0; h_t[c] = '0; h_b[c] = '0;
        end
    endtask

    task automatic push_expected();
        exp_t e;
        e.cyc = cyc_n + LAT;
        for (int c = 0; c < CH; c++) begin
            e.found[c] = (m_cnt[c] >= MINC);
            if (e.found[c]) begin
                h_x[c] = HW'(m_sx[c] / m_cnt[c]);
                h_y[c] = VW'(m_sy[c] / m_cnt[c]);
                h_l[c] = HW'(m_minx[c]); h_r[c] = HW'(m_maxx[c]);
                h_t[c] = VW'(m_miny[c]); h_b[c] = VW'(m_maxy[c]);
            end
            e.x[c*HW +: HW] = h_x[c]; e.l[c*HW +: HW] = h_l[c]; e.r[c*HW +: HW] = h_r[c];
            e.y[c*VW +: VW] = h_y[c]; e.t[c*VW +: VW] = h_t[c]; e.b[c*VW +: VW] = h_b[c];
        end
        sb.push_back(e);
    endtask

    task automatic pix(input int x, input int y, input logic [CH-1:0] m,
                       input logic tab, input logic acc);
        @(negedge clk);
        x_in = HW'(x); y_in = VW'(y); mask_in = m; tabulate_in = tab;
        if (tab) begin
            if (acc) push_expected();
            m_clear();
        end
        if (x < 1024 && y < 768)
            for (int c = 0; c < CH; c++)
                if (m[c]) begin
                    m_cnt[c]++; m_sx[c] += x; m_sy[c] += y;
                    if (x < m_minx[c]) m_minx[c] = x;
                    if (x > m_maxx[c]) m_maxx[c] = x;
                    if (y < m_miny[c]) m_miny[c] = y;
                    if (y > m_maxy[c]) m_maxy[c] = y;
                end
    endtask

    task automatic idle(input int n);
        repeat (n) pix(0, 0, '0, 1'b0, 1'b0);
    endtask

    task automatic wait_done(input string tag);
        int t = 0;
        while (sb.size() != 0 && t < 300) begin
            pix(0, 0, '0, 1'b0, 1'b0);
            t++;
        end
        idle(2);
        chk(tag, sb.size(), 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (overrun_out) ovr_cnt++;
        if (valid_out) begin
            if (sb.size() == 0) chk("unexpected_valid", 1, 0);
            else begin
                e = sb.pop_front();
                chk("latency", cyc_n, e.cyc);
                chk("found", found_out, e.found);
                chk("x_com", x_com_out, e.x);
                chk("y_com", y_com_out, e.y);
                chk("left", left_out, e.l);
                chk("right", right_out, e.r);
                chk("top", top_out, e.t);
                chk("bot", bot_out, e.b);
            end
        end
    end

    initial begin
        m_clear();
        h_clear();
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy_out, 0);
        chk("rst_valid", valid_out, 0);
        chk("rst_overrun", overrun_out, 0);
        chk("rst_found", found_out, 0);
        chk("rst_x_com", x_com_out, 0);
        chk("rst_y_com", y_com_out, 0);
        chk("rst_left", left_out, 0);
        chk("rst_right", right_out, 0);
        chk("rst_top", top_out, 0);
        chk("rst_bot", bot_out, 0);
        rst_n = 1'b1;
        idle(2);

        // Frame A: one location on channel 0, repeated to reach MIN_COUNT
        repeat (16) pix(100, 50, 4'b0001, 1'b0, 1'b0);
        pix(0, 0, '0, 1'b1, 1'b1);
        pix(0, 0, '0, 1'b0, 1'b0);
        chk("busy_after_tab", busy_out, 1);
        wait_done("frame_a_done");
        chk("idle_after_done", busy_out, 0);

        // Frame B: 10x10 block on ch2, 20-pixel line on ch1, out-of-range pixels
        for (int i = 0; i < 10; i++)
            for (int j = 0; j < 10; j++)
                pix(200 + j, 300 + i, 4'b0100, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) pix(500 + i, 400, 4'b0010, 1'b0, 1'b0);
        pix(1024, 5, 4'b0100, 1'b0, 1'b0);
        pix(5, 768, 4'b0100, 1'b0, 1'b0);
        pix(1024, 768, 4'b1000, 1'b0, 1'b0);
        pix(10, 10, 4'b0010, 1'b1, 1'b1);
        wait_done("frame_b_done");

        // Frame C: ch1 reaches only 15 pixels; ch3 at the last in-range corner
        for (int i = 0; i < 14; i++) pix(20 + i, 30, 4'b0010, 1'b0, 1'b0);
        repeat (16) pix(1023, 767, 4'b1000, 1'b0, 1'b0);
        pix(0, 0, '0, 1'b1, 1'b1);
        wait_done("frame_c_done");

        // Frame D with a second strobe 20 cycles later, then frame E
        repeat (16) pix(30, 40, 4'b0001, 1'b0, 1'b0);
        ovr_cnt = 0;
        pix(0, 0, '0, 1'b1, 1'b1);
        repeat (19) pix(7, 7, 4'b0001, 1'b0, 1'b0);
        pix(0, 0, '0, 1'b1, 1'b0);
        repeat (16) pix(60, 70, 4'b0001, 1'b0, 1'b0);
        wait_done("frame_d_done");
        chk("overrun_pulses", ovr_cnt, 1);
        pix(0, 0, '0, 1'b1, 1'b1);
        wait_done("frame_e_done");

        // Frame F aborted by reset during the divide
        repeat (16) pix(11, 22, 4'b0010, 1'b0, 1'b0);
        pix(0, 0, '0, 1'b1, 1'b1);
        idle(40);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy_out, 0);
        chk("abort_found", found_out, 0);
        chk("abort_x_com", x_com_out, 0);
        chk("abort_left", left_out, 0);
        chk("abort_bot", bot_out, 0);
        sb.delete();
        m_clear();
        h_clear();
        @(negedge clk);
        rst_n = 1'b1;
        idle(100);

        // Frame G after reset release
        repeat (16) pix(33, 44, 4'b0010, 1'b0, 1'b0);
        pix(0, 0, '0, 1'b1, 1'b1);
        wait_done("frame_g_done");
        idle(100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
